// File: rtl/keccak_pkg.sv
// Shared constants and rate helpers for the multi-rate keccak input padder.
package keccak_pkg;

  localparam int RATE_MAX = 1152;

  localparam logic [1:0] MODE_224 = 2'd0;
  localparam logic [1:0] MODE_256 = 2'd1;
  localparam logic [1:0] MODE_384 = 2'd2;
  localparam logic [1:0] MODE_512 = 2'd3;

  localparam logic [7:0] PAD_SHA3   = 8'h06;
  localparam logic [7:0] PAD_KECCAK = 8'h01;
  localparam logic [7:0] PAD_END    = 8'h80;

  typedef enum logic {
    ST_ABSORB   = 1'b0,
    ST_WAIT_ACK = 1'b1
  } pad_state_e;

  function automatic int rate_bits(input logic [1:0] mode);
    case (mode)
      MODE_224: return 1152;
      MODE_256: return 1088;
      MODE_384: return 832;
      default:  return 576;
    endcase
  endfunction

  function automatic int words_per_block(input logic [1:0] mode, input int w);
    return rate_bits(mode) / w;
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational padding of the final message word: keep the top byte_num bytes,
// insert the domain pad byte right after them and zero the rest.
module keccak_pad_word
  import keccak_pkg::*;
#(
  parameter int W        = 32,
  parameter bit SHA3_PAD = 1'b1
) (
  input  logic [W-1:0]             word_in,
  input  logic [$clog2(W/8)-1:0]   byte_num,
  input  logic                     is_last,
  output logic [W-1:0]             word_out
);

  localparam int BW = $clog2(W/8);
  localparam logic [7:0] PAD_BYTE = SHA3_PAD ? PAD_SHA3 : PAD_KECCAK;

  // Byte gi counts from the MSB end, matching message byte order.
  for (genvar gi = 0; gi < W/8; gi++) begin : g_byte
    localparam logic [BW-1:0] IDX = BW'(gi);
    assign word_out[W-1-8*gi -: 8] =
        (!is_last || IDX < byte_num) ? word_in[W-1-8*gi -: 8] :
        (IDX == byte_num)            ? PAD_BYTE               : 8'h00;
  end

endmodule

// File: rtl/keccak_padder_multi.sv
// Multi-rate keccak input padder: assembles W-bit words into rate-sized blocks,
// pads the final word in place and hands blocks to the permutation with an ack handshake.
module keccak_padder_multi #(
  parameter int W        = 32,
  parameter bit SHA3_PAD = 1'b1,
  parameter int RATE_MAX = keccak_pkg::RATE_MAX
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             in,
  input  logic                     in_ready,
  input  logic                     is_last,
  input  logic [$clog2(W/8)-1:0]   byte_num,
  input  logic [1:0]               mode,
  output logic                     buffer_full,
  output logic [RATE_MAX-1:0]      out,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     f_ack
);

  import keccak_pkg::*;

  localparam int NMAX = RATE_MAX / W;
  localparam int CW   = $clog2(NMAX);

  pad_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            in_msg_q, in_msg_d;
  logic            last_q, last_d;

  logic            accept;
  logic            clear;
  logic [1:0]      eff_mode;
  logic [CW-1:0]   last_slot;
  logic [W-1:0]    padded;

  // The live mode input only matters on the first word of a message.
  assign eff_mode    = in_msg_q ? mode_q : mode;
  assign last_slot   = CW'(words_per_block(eff_mode, W) - 1);
  assign accept      = in_ready && (state_q == ST_ABSORB);
  assign clear       = f_ack && (state_q == ST_WAIT_ACK);
  assign buffer_full = (state_q == ST_WAIT_ACK);
  assign out_valid   = (state_q == ST_WAIT_ACK);
  assign out_last    = last_q;

  keccak_pad_word #(
    .W        (W),
    .SHA3_PAD (SHA3_PAD)
  ) u_pad (
    .word_in  (in),
    .byte_num (byte_num),
    .is_last  (is_last),
    .word_out (padded)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    in_msg_d = in_msg_q;
    last_d   = last_q;
    case (state_q)
      ST_ABSORB: begin
        if (accept) begin
          mode_d = eff_mode;
          if (is_last) begin
            state_d  = ST_WAIT_ACK;
            last_d   = 1'b1;
            in_msg_d = 1'b0;
          end else begin
            in_msg_d = 1'b1;
            if (cnt_q == last_slot) begin
              state_d = ST_WAIT_ACK;
              last_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      ST_WAIT_ACK: begin
        if (f_ack) begin
          state_d = ST_ABSORB;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = ST_ABSORB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_ABSORB;
      cnt_q    <= '0;
      mode_q   <= MODE_224;
      in_msg_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      in_msg_q <= in_msg_d;
      last_q   <= last_d;
    end
  end

  // Slots are zeroed on ack, so untouched slots of a padded block are already zero.
  for (genvar gi = 0; gi < NMAX; gi++) begin : g_slot
    localparam logic [CW-1:0] IDX = CW'(gi);
    logic [W-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (clear) slot_d = '0;
      if (accept && cnt_q == IDX) slot_d = padded;
      if (accept && is_last && last_slot == IDX) slot_d[7:0] = slot_d[7:0] | PAD_END;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) slot_q <= '0;
      else        slot_q <= slot_d;
    end

    assign out[RATE_MAX-1-gi*W -: W] = slot_q;
  end

endmodule

// File: tb/tb_keccak_padder_multi.sv
// Scoreboard bench for keccak_padder_multi: a W=32 SHA-3 instance and a W=64 Keccak instance.
module tb_keccak_padder_multi;

  typedef logic [1151:0] blk_t;
  typedef byte unsigned bq_t[$];
  typedef logic [31:0] wq32_t[$];

  logic clk = 1'b0;
  logic rst_n;

  logic [31:0]   in32;
  logic          in_ready32, is_last32, f_ack32;
  logic [1:0]    bn32, mode32;
  logic          buffer_full32, out_valid32, out_last32;
  logic [1151:0] out32;

  logic [63:0]   in64;
  logic          in_ready64, is_last64, f_ack64;
  logic [2:0]    bn64;
  logic [1:0]    mode64;
  logic          buffer_full64, out_valid64, out_last64;
  logic [1151:0] out64;

  int vectors = 0;
  int errors  = 0;

  blk_t exp32_q[$], exp64_q[$];
  bit   explast32_q[$], explast64_q[$];
  blk_t last_blk32;
  bit   seen32 = 1'b0, seen64 = 1'b0;
  int   nblk32 = 0, nblk64 = 0;

  always #5 clk = ~clk;

  keccak_padder_multi #(.W(32), .SHA3_PAD(1'b1), .RATE_MAX(1152)) u_dut32 (
    .clk(clk), .reset(rst_n), .in(in32), .in_ready(in_ready32), .is_last(is_last32),
    .byte_num(bn32), .mode(mode32), .buffer_full(buffer_full32), .out(out32),
    .out_valid(out_valid32), .out_last(out_last32), .f_ack(f_ack32)
  );

  keccak_padder_multi #(.W(64), .SHA3_PAD(1'b0), .RATE_MAX(1152)) u_dut64 (
    .clk(clk), .reset(rst_n), .in(in64), .in_ready(in_ready64), .is_last(is_last64),
    .byte_num(bn64), .mode(mode64), .buffer_full(buffer_full64), .out(out64),
    .out_valid(out_valid64), .out_last(out_last64), .f_ack(f_ack64)
  );

  function automatic int rate_bytes(input logic [1:0] m);
    case (m)
      2'd0:    return 144;
      2'd1:    return 136;
      2'd2:    return 104;
      default: return 72;
    endcase
  endfunction

  // Byte-level reference: append pad byte, zero-fill to the rate, OR 0x80 into the final byte.
  task automatic model_push(input bit sel, input bq_t msg, input int rb, input logic [7:0] padb);
    bq_t  p;
    blk_t blk;
    int   nblk;
    p = msg;
    p.push_back(padb);
    while (p.size() % rb != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / rb;
    for (int k = 0; k < nblk; k++) begin
      blk = '0;
      for (int i = 0; i < rb; i++) blk[1151-8*i -: 8] = p[k*rb+i];
      if (sel) begin
        exp64_q.push_back(blk);
        explast64_q.push_back(k == nblk-1);
      end else begin
        exp32_q.push_back(blk);
        explast32_q.push_back(k == nblk-1);
        last_blk32 = blk;
      end
    end
  endtask

  task automatic push_msg32(input wq32_t words, input int bn, input logic [1:0] md);
    bq_t msg;
    int  nb;
    for (int i = 0; i < words.size(); i++) begin
      nb = (i == words.size()-1) ? bn : 4;
      for (int k = 0; k < nb; k++) msg.push_back(words[i][31-8*k -: 8]);
    end
    model_push(1'b0, msg, rate_bytes(md), 8'h06);
  endtask

  task automatic send32(input logic [31:0] w, input bit last, input logic [1:0] bn, input logic [1:0] md);
    int guard = 0;
    in32 = w; is_last32 = last; bn32 = bn; mode32 = md; in_ready32 = 1'b1;
    while (buffer_full32 !== 1'b0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      vectors++; errors++;
      $display("FAIL send32_timeout: buffer_full=%b want 0 within 50 cycles", buffer_full32);
    end
    @(posedge clk); #1;
    in_ready32 = 1'b0;
  endtask

  task automatic send64(input logic [63:0] w, input bit last, input logic [2:0] bn, input logic [1:0] md);
    int guard = 0;
    in64 = w; is_last64 = last; bn64 = bn; mode64 = md; in_ready64 = 1'b1;
    while (buffer_full64 !== 1'b0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      vectors++; errors++;
      $display("FAIL send64_timeout: buffer_full=%b want 0 within 50 cycles", buffer_full64);
    end
    @(posedge clk); #1;
    in_ready64 = 1'b0;
  endtask

  task automatic ack32();
    f_ack32 = 1'b1;
    @(posedge clk); #1;
    f_ack32 = 1'b0;
  endtask

  task automatic ack64();
    f_ack64 = 1'b1;
    @(posedge clk); #1;
    f_ack64 = 1'b0;
  endtask

  task automatic run_msg32(input wq32_t words, input int bn, input logic [1:0] md);
    push_msg32(words, bn, md);
    for (int i = 0; i < words.size(); i++) begin
      send32(words[i], i == words.size()-1, (i == words.size()-1) ? 2'(bn) : 2'd0, md);
      if (i != words.size()-1 && out_valid32 === 1'b1) ack32();
    end
  endtask

  // Scoreboard monitors: pop one expected block per rising out_valid.
  always @(negedge clk) begin
    if (out_valid32 === 1'b1 && !seen32) begin
      blk_t eb;
      bit   el;
      int   ds;
      seen32 = 1'b1;
      vectors++;
      if (exp32_q.size() == 0) begin
        errors++;
        $display("FAIL blk32_unexpected: got block with out_last=%b, want no block", out_last32);
      end else begin
        eb = exp32_q.pop_front();
        el = explast32_q.pop_front();
        ds = -1;
        for (int s = 35; s >= 0; s--) if (out32[1151-32*s -: 32] !== eb[1151-32*s -: 32]) ds = s;
        if (out32 !== eb || out_last32 !== el) begin
          errors++;
          $display("FAIL blk32_%0d: slot %0d got %h want %h, out_last got %b want %b", nblk32, ds,
                   (ds >= 0) ? out32[1151-32*ds -: 32] : 32'h0, (ds >= 0) ? eb[1151-32*ds -: 32] : 32'h0,
                   out_last32, el);
        end else begin
          $display("block32 %0d last=%b matched", nblk32, el);
        end
      end
      nblk32++;
    end else if (out_valid32 !== 1'b1) begin
      seen32 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (out_valid64 === 1'b1 && !seen64) begin
      blk_t eb;
      bit   el;
      int   ds;
      seen64 = 1'b1;
      vectors++;
      if (exp64_q.size() == 0) begin
        errors++;
        $display("FAIL blk64_unexpected: got block with out_last=%b, want no block", out_last64);
      end else begin
        eb = exp64_q.pop_front();
        el = explast64_q.pop_front();
        ds = -1;
        for (int s = 35; s >= 0; s--) if (out64[1151-32*s -: 32] !== eb[1151-32*s -: 32]) ds = s;
        if (out64 !== eb || out_last64 !== el) begin
          errors++;
          $display("FAIL blk64_%0d: half-slot %0d got %h want %h, out_last got %b want %b", nblk64, ds,
                   (ds >= 0) ? out64[1151-32*ds -: 32] : 32'h0, (ds >= 0) ? eb[1151-32*ds -: 32] : 32'h0,
                   out_last64, el);
        end else begin
          $display("block64 %0d last=%b matched", nblk64, el);
        end
      end
      nblk64++;
    end else if (out_valid64 !== 1'b1) begin
      seen64 = 1'b0;
    end
  end

  task automatic test_reset();
    vectors++;
    if ({out_valid32, out_last32, buffer_full32} !== 3'b000) begin
      errors++; $display("FAIL reset32_flags: got %b want 000", {out_valid32, out_last32, buffer_full32});
    end
    vectors++;
    if (out32 !== '0) begin errors++; $display("FAIL reset32_out: got nonzero want 0"); end
    vectors++;
    if ({out_valid64, out_last64, buffer_full64} !== 3'b000) begin
      errors++; $display("FAIL reset64_flags: got %b want 000", {out_valid64, out_last64, buffer_full64});
    end
    vectors++;
    if (out64 !== '0) begin errors++; $display("FAIL reset64_out: got nonzero want 0"); end
  endtask

  task automatic test_hello();
    wq32_t w;
    w = '{32'h48656c6c, 32'h6f2c2077, 32'h6f726c64, 32'h21202020};
    push_msg32(w, 1, 2'd1);
    send32(w[0], 1'b0, 2'd0, 2'd1);
    ack32();
    vectors++;
    if ({out_valid32, buffer_full32} !== 2'b00) begin
      errors++; $display("FAIL idle_ack: got valid/full %b want 00", {out_valid32, buffer_full32});
    end
    send32(w[1], 1'b0, 2'd0, 2'd1);
    send32(w[2], 1'b0, 2'd0, 2'd1);
    vectors++;
    if (out_valid32 !== 1'b0) begin errors++; $display("FAIL hello_early_valid: got %b want 0", out_valid32); end
    send32(w[3], 1'b1, 2'd1, 2'd1);
    vectors++;
    if ({out_valid32, out_last32} !== 2'b11) begin
      errors++; $display("FAIL hello_latency: got valid/last %b want 11", {out_valid32, out_last32});
    end
    vectors++;
    if (out32[1151-3*32 -: 32] !== 32'h21060000) begin
      errors++; $display("FAIL hello_slot3: got %h want 21060000", out32[1151-3*32 -: 32]);
    end
    vectors++;
    if (out32[1151-33*32 -: 32] !== 32'h00000080) begin
      errors++; $display("FAIL hello_slot33: got %h want 00000080", out32[1151-33*32 -: 32]);
    end
    vectors++;
    if (out32[1151-4*32 : 1152-33*32] !== '0 || out32[63:0] !== '0) begin
      errors++; $display("FAIL hello_zero_fill: got nonzero want 0");
    end
    ack32();
    vectors++;
    if ({out_valid32, buffer_full32, out_last32} !== 3'b000) begin
      errors++; $display("FAIL hello_ack: got %b want 000", {out_valid32, buffer_full32, out_last32});
    end
  endtask

  task automatic test_empty();
    wq32_t w;
    w = '{32'hdeadbeef};
    run_msg32(w, 0, 2'd3);
    vectors++;
    if (out32[1151 -: 32] !== 32'h06000000 || out32[1151-17*32 -: 32] !== 32'h00000080) begin
      errors++; $display("FAIL empty_pad: got %h/%h want 06000000/00000080",
                         out32[1151 -: 32], out32[1151-17*32 -: 32]);
    end
    vectors++;
    if (out32[575:0] !== '0) begin errors++; $display("FAIL empty_low_bits: got nonzero want 0"); end
    ack32();
  endtask

  task automatic test_full_rate();
    wq32_t w;
    for (int i = 0; i < 35; i++) w.push_back($urandom());
    run_msg32(w, 0, 2'd1);
    vectors++;
    if (out_last32 !== 1'b1 || out32[1151 -: 32] !== 32'h06000000 || out32[1151-33*32 -: 32] !== 32'h80) begin
      errors++; $display("FAIL full_rate_pad_block: got last=%b %h/%h want 1 06000000/00000080",
                         out_last32, out32[1151 -: 32], out32[1151-33*32 -: 32]);
    end
    ack32();
  endtask

  task automatic test_abc_edge();
    wq32_t w;
    for (int i = 0; i < 33; i++) w.push_back($urandom());
    w.push_back(32'h61626300);
    run_msg32(w, 3, 2'd1);
    vectors++;
    if (out32[1151-33*32 -: 32] !== 32'h61626386) begin
      errors++; $display("FAIL abc_slot33: got %h want 61626386", out32[1151-33*32 -: 32]);
    end
  endtask

  task automatic test_back_to_back();
    wq32_t w;
    blk_t  held;
    held = last_blk32;
    w = '{32'h11223344};
    push_msg32(w, 2, 2'd2);
    in32 = 32'h11223344; is_last32 = 1'b1; bn32 = 2'd2; mode32 = 2'd2; in_ready32 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (buffer_full32 !== 1'b1) begin
        errors++; $display("FAIL hold_full_%0d: got %b want 1", c, buffer_full32);
      end
      vectors++;
      if (out32 !== held) begin errors++; $display("FAIL hold_out_%0d: out changed under backpressure", c); end
    end
    f_ack32 = 1'b1;
    @(posedge clk); #1;
    f_ack32 = 1'b0;
    vectors++;
    if ({out_valid32, buffer_full32} !== 2'b00) begin
      errors++; $display("FAIL ack_with_word: got valid/full %b want 00", {out_valid32, buffer_full32});
    end
    @(posedge clk); #1;
    in_ready32 = 1'b0;
    vectors++;
    if (out_valid32 !== 1'b1 || out32[1151 -: 32] !== 32'h11220600 || out32[1151-25*32 -: 32] !== 32'h80) begin
      errors++; $display("FAIL retry_accept: got valid=%b %h/%h want 1 11220600/00000080",
                         out_valid32, out32[1151 -: 32], out32[1151-25*32 -: 32]);
    end
    ack32();
  endtask

  task automatic test_w64_reset_mode();
    logic [63:0] w[9];
    bq_t msg;
    for (int i = 0; i < 4; i++) send64({$urandom(), $urandom()}, 1'b0, 3'd0, 2'd3);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out64 !== '0 || {out_valid64, out_last64, buffer_full64} !== 3'b000) begin
      errors++; $display("FAIL async_reset64: got flags %b out nonzero=%b want 000/0",
                         {out_valid64, out_last64, buffer_full64}, out64 !== '0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      w[i] = {$urandom(), $urandom()};
      for (int k = 0; k < 8; k++) msg.push_back(w[i][63-8*k -: 8]);
    end
    model_push(1'b1, msg, 72, 8'h01);
    send64(w[0], 1'b0, 3'd0, 2'd3);
    for (int i = 1; i < 9; i++) send64(w[i], 1'b0, 3'd0, 2'd0);
    vectors++;
    if ({out_valid64, out_last64} !== 2'b10) begin
      errors++; $display("FAIL mode_latch64: got valid/last %b want 10", {out_valid64, out_last64});
    end
    ack64();
    send64(64'h0123456789abcdef, 1'b1, 3'd0, 2'd0);
    vectors++;
    if (out_last64 !== 1'b1 || out64[1151 -: 64] !== 64'h0100000000000000 || out64[1151-8*64 -: 64] !== 64'h80) begin
      errors++; $display("FAIL keccak_pad64: got last=%b %h/%h want 1 0100000000000000/0000000000000080",
                         out_last64, out64[1151 -: 64], out64[1151-8*64 -: 64]);
    end
    vectors++;
    if (out64[575:0] !== '0) begin errors++; $display("FAIL pad64_low_bits: got nonzero want 0"); end
    ack64();
  endtask

  initial begin
    rst_n = 1'b0;
    in32 = '0; in_ready32 = 1'b0; is_last32 = 1'b0; bn32 = '0; mode32 = '0; f_ack32 = 1'b0;
    in64 = '0; in_ready64 = 1'b0; is_last64 = 1'b0; bn64 = '0; mode64 = '0; f_ack64 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_hello();
    test_empty();
    test_full_rate();
    test_abc_edge();
    test_back_to_back();
    test_w64_reset_mode();

    repeat (2) @(posedge clk);
    vectors++;
    if (exp32_q.size() != 0 || exp64_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", exp32_q.size(), exp64_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
